// File: rtl/pim_pkg.sv
// Shared types and constants for the PIM command issuer slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pim_pkg;

    // Default address width and largest legal matrix dimension.
    localparam int LEN             = 10;
    localparam int MAX_MATRIX_SIZE = 16;
    localparam int SIZE_W          = 5;

    // One queued host command: three matrix base addresses plus dimension N.
    typedef struct packed {
        logic [LEN-1:0]    src1;
        logic [LEN-1:0]    src2;
        logic [LEN-1:0]    dst;
        logic [SIZE_W-1:0] size;
    } pim_cmd_t;

    // Issuer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } pim_state_t;

endpackage

// File: rtl/pim_cmd_fifo.sv
// Synchronous FIFO of pim_cmd_t entries with an occupancy count.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
module pim_cmd_fifo
    import pim_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pim_cmd_t                 push_dat,
    input  logic                     pop,
    output pim_cmd_t                 pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    pim_cmd_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pim_cmd_issuer.sv
// Queues host matrix commands, checks bounds, and issues them one at a time to the memory stage.
// Latency: command accepted into an empty queue while idle at edge N -> start pulse after edge N+1.
// Backpressure: cmd_ready drops when the queue holds DEPTH entries; illegal commands are consumed and flagged.
module pim_cmd_issuer
    import pim_pkg::pim_cmd_t, pim_pkg::pim_state_t, pim_pkg::IDLE, pim_pkg::ISSUE, pim_pkg::WAIT;
#(
    parameter int LEN             = 10,
    parameter int MEM_ELEMENTS    = 1024,
    parameter int MAX_MATRIX_SIZE = 16,
    parameter int DEPTH           = 4,
    parameter int TIMEOUT         = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [LEN-1:0]           cmd_src1,
    input  logic [LEN-1:0]           cmd_src2,
    input  logic [LEN-1:0]           cmd_dst,
    input  logic [4:0]               cmd_size,
    output logic [LEN-1:0]           src1_addr,
    output logic [LEN-1:0]           src2_addr,
    output logic [LEN-1:0]           dst_addr,
    output logic [4:0]               matrix_size,
    output logic                     start,
    input  logic                     mem_done,
    output logic                     busy,
    output logic                     cmd_err,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [15:0]              done_count
);

    // Bounds arithmetic is wide enough that base + N*N can never wrap.
    localparam int AW = LEN + 12;
    localparam int TW = $clog2(TIMEOUT + 1);

    pim_cmd_t        push_dat;
    pim_cmd_t        head_dat;
    logic            q_full;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    logic            xfer;
    logic            size_ok;
    logic            cmd_legal;
    logic [AW-1:0]   area;
    logic [AW-1:0]   end_src1;
    logic [AW-1:0]   end_src2;
    logic [AW-1:0]   end_dst;
    logic [AW-1:0]   mem_lim;
    pim_state_t      state;
    logic [TW-1:0]   wait_cnt;

    // Ready depends only on occupancy, never on a pop happening this cycle.
    assign cmd_ready = rst & ~q_full;
    assign xfer      = cmd_valid & cmd_ready;

    // Command legality: 1 <= N <= MAX and every matrix fits inside memory.
    always_comb begin
        area      = AW'(cmd_size) * AW'(cmd_size);
        end_src1  = AW'(cmd_src1) + area;
        end_src2  = AW'(cmd_src2) + area;
        end_dst   = AW'(cmd_dst) + area;
        mem_lim   = AW'(MEM_ELEMENTS);
        size_ok   = (cmd_size != '0) && (int'(cmd_size) <= MAX_MATRIX_SIZE);
        cmd_legal = size_ok && (end_src1 <= mem_lim) && (end_src2 <= mem_lim)
                    && (end_dst <= mem_lim);
    end

    // Pack the host fields into a queue entry.
    always_comb begin
        push_dat      = '0;
        push_dat.src1 = cmd_src1;
        push_dat.src2 = cmd_src2;
        push_dat.dst  = cmd_dst;
        push_dat.size = cmd_size;
    end

    assign q_push = xfer & cmd_legal;
    assign q_pop  = (state == IDLE) & ~q_empty;

    pim_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (push_dat),
        .pop      (q_pop),
        .pop_dat  (head_dat),
        .count    (queue_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Rejected transfers raise cmd_err for exactly the following cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= xfer & ~cmd_legal;
        end
    end

    // Issue sequencer: pop head in IDLE, pulse start in ISSUE, wait for completion or watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            start       <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            done_count  <= '0;
            wait_cnt    <= '0;
            src1_addr   <= '0;
            src2_addr   <= '0;
            dst_addr    <= '0;
            matrix_size <= '0;
        end else begin
            start   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        src1_addr   <= head_dat.src1;
                        src2_addr   <= head_dat.src2;
                        dst_addr    <= head_dat.dst;
                        matrix_size <= head_dat.size;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        done_count <= done_count + 16'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pim_cmd_issuer.sv
// Randomized and directed bench for pim_cmd_issuer with a transaction-level reference model.
// Latency: model predicts outputs edge by edge; outputs compared on every falling edge.
// Backpressure: stimulus honours cmd_ready when a command must be accepted.
module tb_pim_cmd_issuer;

    localparam int LEN     = 10;
    localparam int MEM     = 1024;
    localparam int MAXN    = 16;
    localparam int DEPTH   = 4;
    localparam int TMO     = 50;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [LEN-1:0]  cmd_src1 = '0;
    logic [LEN-1:0]  cmd_src2 = '0;
    logic [LEN-1:0]  cmd_dst = '0;
    logic [4:0]      cmd_size = '0;
    logic [LEN-1:0]  src1_addr;
    logic [LEN-1:0]  src2_addr;
    logic [LEN-1:0]  dst_addr;
    logic [4:0]      matrix_size;
    logic            start;
    logic            mem_done = 1'b0;
    logic            busy;
    logic            cmd_err;
    logic            timeout;
    logic [CW-1:0]   queue_count;
    logic [15:0]     done_count;

    pim_cmd_issuer #(
        .LEN             (LEN),
        .MEM_ELEMENTS    (MEM),
        .MAX_MATRIX_SIZE (MAXN),
        .DEPTH           (DEPTH),
        .TIMEOUT         (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_src1    (cmd_src1),
        .cmd_src2    (cmd_src2),
        .cmd_dst     (cmd_dst),
        .cmd_size    (cmd_size),
        .src1_addr   (src1_addr),
        .src2_addr   (src2_addr),
        .dst_addr    (dst_addr),
        .matrix_size (matrix_size),
        .start       (start),
        .mem_done    (mem_done),
        .busy        (busy),
        .cmd_err     (cmd_err),
        .timeout     (timeout),
        .queue_count (queue_count),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int s1;
        int s2;
        int d;
        int sz;
    } mcmd_t;

    mcmd_t mq[$];
    int    m_edge = 0;
    int    m_pop_edge = 0;
    bit    m_inflight = 0;
    bit    m_start = 0;
    bit    m_busy = 0;
    bit    m_err = 0;
    bit    m_to = 0;
    int    m_done = 0;
    int    m_s1 = 0;
    int    m_s2 = 0;
    int    m_d = 0;
    int    m_sz = 0;
    bit    chk_en = 0;

    function automatic bit m_legal(int s1, int s2, int d, int sz);
        return (sz >= 1) && (sz <= MAXN) && (s1 + sz * sz <= MEM)
               && (s2 + sz * sz <= MEM) && (d + sz * sz <= MEM);
    endfunction

    // Predict the state of every output after each rising edge from the inputs seen at it.
    always @(posedge clk) begin : model
        bit    was_idle;
        bit    can_take;
        bit    lg;
        mcmd_t c;
        if (!rst) begin
            mq.delete();
            m_inflight = 0;
            m_start = 0;
            m_busy = 0;
            m_err = 0;
            m_to = 0;
            m_done = 0;
            m_s1 = 0;
            m_s2 = 0;
            m_d = 0;
            m_sz = 0;
        end else begin
            was_idle = !m_inflight;
            can_take = mq.size() < DEPTH;
            lg = m_legal(int'(cmd_src1), int'(cmd_src2), int'(cmd_dst), int'(cmd_size));
            m_start = 0;
            m_to = 0;
            m_err = cmd_valid && can_take && !lg;
            if (m_inflight && (m_edge - m_pop_edge >= 2)) begin
                if (mem_done) begin
                    m_done = (m_done + 1) & 16'hFFFF;
                    m_inflight = 0;
                end else if (m_edge - m_pop_edge == TMO + 1) begin
                    m_to = 1;
                    m_inflight = 0;
                end
            end
            if (was_idle && mq.size() > 0) begin
                c = mq.pop_front();
                m_s1 = c.s1;
                m_s2 = c.s2;
                m_d = c.d;
                m_sz = c.sz;
                m_start = 1;
                m_inflight = 1;
                m_pop_edge = m_edge;
            end
            if (cmd_valid && can_take && lg) begin
                c.s1 = int'(cmd_src1);
                c.s2 = int'(cmd_src2);
                c.d = int'(cmd_dst);
                c.sz = int'(cmd_size);
                mq.push_back(c);
            end
            m_busy = m_inflight;
        end
        m_edge++;
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("start", start, m_start);
            check("busy", busy, m_busy);
            check("cmd_err", cmd_err, m_err);
            check("timeout", timeout, m_to);
            check("done_count", done_count, m_done);
            check("queue_count", queue_count, mq.size());
            check("cmd_ready", cmd_ready, rst && (mq.size() < DEPTH));
            check("src1_addr", src1_addr, m_s1);
            check("src2_addr", src2_addr, m_s2);
            check("dst_addr", dst_addr, m_d);
            check("matrix_size", matrix_size, m_sz);
        end
    end

    // ---------------- stimulus ----------------
    int seen[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int s1, input int s2, input int d, input int sz);
        cmd_src1 = LEN'(s1);
        cmd_src2 = LEN'(s2);
        cmd_dst  = LEN'(d);
        cmd_size = 5'(sz);
    endtask

    task automatic push_cmd(input int s1, input int s2, input int d, input int sz);
        bit acc;
        acc = 0;
        set_cmd(s1, s2, d, sz);
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("push_accept_bound", acc, 1);
    endtask

    task automatic drain(input string name);
        bit fin;
        fin = 0;
        seen.delete();
        for (int i = 0; i < 600 && !fin; i++) begin
            mem_done = busy && !start && ($urandom_range(0, 3) == 0);
            tick();
            if (start) seen.push_back(int'(src1_addr));
            fin = (queue_count == 0) && !busy;
        end
        mem_done = 1'b0;
        check(name, fin, 1);
    endtask

    initial begin
        int bad_s1[3];
        int bad_sz[3];
        int cnt;
        int saved_done;
        bit got;

        bad_s1 = '{0, 0, 'h3F0};
        bad_sz = '{0, 17, 8};

        // Reset state
        rst = 1'b0;
        tick();
        chk_en = 1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_qcount", queue_count, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_done", done_count, 0);
        check("rst_addr", src1_addr, 0);
        rst = 1'b1;
        tick();

        // First command latency and completion
        set_cmd('h000, 'h100, 'h200, 8);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_qcount_n", queue_count, 1);
        check("lat_start_n", start, 0);
        tick();
        check("lat_start_n1", start, 1);
        check("lat_src1", src1_addr, 'h000);
        check("lat_src2", src2_addr, 'h100);
        check("lat_dst", dst_addr, 'h200);
        check("lat_size", matrix_size, 8);
        check("lat_busy", busy, 1);
        tick();
        check("lat_start_once", start, 0);
        repeat (18) tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("first_done_count", done_count, 1);
        check("first_done_busy", busy, 0);

        // Illegal commands
        for (int i = 0; i < 3; i++) begin
            set_cmd(bad_s1[i], 0, 0, bad_sz[i]);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            check("illegal_err", cmd_err, 1);
            check("illegal_qcount", queue_count, 0);
            tick();
            check("illegal_err_clear", cmd_err, 0);
            check("illegal_no_start", start, 0);
        end

        // Fill the queue, then drain in FIFO order
        for (int i = 0; i < 5; i++) push_cmd(i * 64, i * 64 + 1, i * 64 + 2, 2 + i);
        check("full_qcount", queue_count, 4);
        check("full_ready", cmd_ready, 0);
        drain("drain1_bound");
        check("fifo_issued", seen.size(), 4);
        for (int i = 0; i < seen.size() && i < 4; i++) check("fifo_order", seen[i], (i + 1) * 64);

        // Watchdog
        saved_done = int'(done_count);
        push_cmd(5, 6, 7, 3);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (start) got = 1;
            else tick();
        end
        check("tmo_start_seen", got, 1);
        cnt = 0;
        while (!timeout && cnt < TMO + 20) begin
            tick();
            cnt++;
        end
        check("tmo_latency", cnt, TMO + 1);
        check("tmo_busy", busy, 0);
        check("tmo_done_same", done_count, saved_done);

        // Reset while waiting with two queued
        push_cmd(10, 20, 30, 2);
        push_cmd(40, 50, 60, 2);
        push_cmd(70, 80, 90, 2);
        tick();
        check("rw_qcount_pre", queue_count, 2);
        check("rw_busy_pre", busy, 1);
        rst = 1'b0;
        tick();
        check("rw_qcount", queue_count, 0);
        check("rw_busy", busy, 0);
        check("rw_done", done_count, 0);
        rst = 1'b1;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("rw_late_done", done_count, 0);
        check("rw_late_busy", busy, 0);

        // Push and pop on the same edge at count 2
        push_cmd(100, 101, 102, 4);
        push_cmd(200, 201, 202, 4);
        push_cmd(300, 301, 302, 4);
        tick();
        check("pp_qcount_pre", queue_count, 2);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        set_cmd(400, 401, 402, 4);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("pp_qcount", queue_count, 2);
        check("pp_start", start, 1);
        check("pp_src1", src1_addr, 200);
        drain("drain2_bound");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sz;
            int lim;
            int mode;
            mode = (i / 300) % 3;
            sz = $urandom_range(0, 18);
            lim = MEM - sz * sz;
            if (lim < 0) lim = 0;
            rst = ($urandom_range(0, 399) != 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            set_cmd(($urandom_range(0, 7) == 0) ? lim + $urandom_range(0, 1) : $urandom_range(0, lim),
                    ($urandom_range(0, 15) == 0) ? lim + 1 : $urandom_range(0, lim),
                    ($urandom_range(0, 15) == 0) ? lim + 1 : $urandom_range(0, lim),
                    sz);
            if (mode == 0) mem_done = ($urandom_range(0, 3) == 0);
            else if (mode == 1) mem_done = ($urandom_range(0, 19) == 0);
            else mem_done = 1'b0;
            tick();
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        mem_done = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
